// File: rtl/ripple_cnt_reader_pkg.sv
// rtl/ripple_cnt_reader_pkg.sv - shared types, default widths and step arithmetic for ripple_cnt_reader
package rcr_pkg;

  localparam int CNT_W_DEF         = 4;
  localparam int ACC_W_DEF         = 16;
  localparam int STABLE_CYCLES_DEF = 3;
  localparam int MAX_STEP_DEF      = 4;

  typedef enum logic [1:0] {IDLE, SETTLE, UPDATE} state_t;

  // Direction picks which way around the modulo-2^cnt_w ring the counter moved.
  function automatic int step_calc(input int cand, input int last, input logic dir, input int cnt_w);
    int mask;
    mask = (1 << cnt_w) - 1;
    if (dir) step_calc = (cand - last) & mask;
    else     step_calc = -((last - cand) & mask);
  endfunction

endpackage

// File: rtl/ripple_cnt_reader_if.sv
// rtl/ripple_cnt_reader_if.sv - counter input / accumulator output bundle for ripple_cnt_reader
interface ripple_cnt_reader_if
  import rcr_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) ();

  logic [CNT_W-1:0] cnt_async;
  logic             up_down;
  logic             clr;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] delta;
  logic             acc_valid;
  logic             step_err;
  logic             sat;

  modport master (output cnt_async, up_down, clr,
                  input  acc, delta, acc_valid, step_err, sat);
  modport slave  (input  cnt_async, up_down, clr,
                  output acc, delta, acc_valid, step_err, sat);

endinterface

// File: rtl/ripple_cnt_reader_sync_2ff.sv
// rtl/ripple_cnt_reader_sync_2ff.sv - parameterised-width two-flop synchroniser, async active-high reset
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/ripple_cnt_reader.sv
// rtl/ripple_cnt_reader.sv - glitch-filtered reader/accumulator for an async up/down ripple counter
// Optional clamp-on-overflow accumulator: define RCR_SATURATE_EN.
module ripple_cnt_reader
  import rcr_pkg::*;
#(
  parameter int CNT_W         = CNT_W_DEF,
  parameter int ACC_W         = ACC_W_DEF,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int MAX_STEP      = MAX_STEP_DEF
) (
  input  logic                clk,
  input  logic                rst,
  ripple_cnt_reader_if.slave  bus
);

  localparam int SC_W = $clog2(STABLE_CYCLES + 1);

  logic [CNT_W:0]   sync_out;
  logic [CNT_W-1:0] s_cnt;
  logic             s_dir;

  sync_2ff #(.W(CNT_W + 1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   ({bus.up_down, bus.cnt_async}),
    .q   (sync_out)
  );

  assign s_dir = sync_out[CNT_W];
  assign s_cnt = sync_out[CNT_W-1:0];

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cand_q, cand_d;
  logic [SC_W-1:0]  scnt_q, scnt_d;
  logic [CNT_W-1:0] last_q, last_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] delta_q, delta_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  int               step_i;
  int               step_mag;
`ifdef RCR_SATURATE_EN
  logic             sat_q, sat_d;
  logic [ACC_W:0]   sum;
`endif

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    scnt_d   = scnt_q;
    last_d   = last_q;
    acc_d    = acc_q;
    delta_d  = delta_q;
    valid_d  = 1'b0;
    err_d    = err_q;
    step_i   = 0;
    step_mag = 0;
`ifdef RCR_SATURATE_EN
    sat_d    = sat_q;
    sum      = '0;
`endif
    case (state_q)
      IDLE: begin
        if (s_cnt != last_q) begin
          cand_d  = s_cnt;
          scnt_d  = SC_W'(1);
          state_d = (STABLE_CYCLES <= 1) ? UPDATE : SETTLE;
        end
      end
      SETTLE: begin
        if (s_cnt != cand_q) begin
          cand_d = s_cnt;
          scnt_d = SC_W'(1);
        end else begin
          scnt_d = scnt_q + SC_W'(1);
          // A ripple that settles back onto the old value is not a count.
          if (int'(scnt_q) + 1 >= STABLE_CYCLES)
            state_d = (cand_q == last_q) ? IDLE : UPDATE;
        end
      end
      UPDATE: begin
        step_i   = step_calc(int'(cand_q), int'(last_q), s_dir, CNT_W);
        step_mag = (step_i < 0) ? -step_i : step_i;
`ifdef RCR_SATURATE_EN
        sum = {acc_q[ACC_W-1], acc_q} + (ACC_W + 1)'(step_i);
        if (sum[ACC_W] != sum[ACC_W-1]) begin
          acc_d = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
          sat_d = 1'b1;
        end else begin
          acc_d = sum[ACC_W-1:0];
        end
`else
        acc_d = acc_q + ACC_W'(step_i);
`endif
        if (step_mag > MAX_STEP) err_d = 1'b1;
        delta_d = CNT_W'(step_i);
        last_d  = cand_q;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Clear beats a coincident update for the accumulator and flags only.
    if (bus.clr) begin
      acc_d = '0;
      err_d = 1'b0;
`ifdef RCR_SATURATE_EN
      sat_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cand_q  <= '0;
      scnt_q  <= '0;
      last_q  <= '0;
      acc_q   <= '0;
      delta_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef RCR_SATURATE_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      scnt_q  <= scnt_d;
      last_q  <= last_d;
      acc_q   <= acc_d;
      delta_q <= delta_d;
      valid_q <= valid_d;
      err_q   <= err_d;
`ifdef RCR_SATURATE_EN
      sat_q   <= sat_d;
`endif
    end
  end

  assign bus.acc       = acc_q;
  assign bus.delta     = delta_q;
  assign bus.acc_valid = valid_q;
  assign bus.step_err  = err_q;
`ifdef RCR_SATURATE_EN
  assign bus.sat       = sat_q;
`else
  assign bus.sat       = 1'b0;
`endif

endmodule

// File: tb/tb_ripple_cnt_reader.sv
// tb/tb_ripple_cnt_reader.sv - self-checking bench for ripple_cnt_reader with a behavioural model
module tb_ripple_cnt_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ripple_cnt_reader_if bus ();
  ripple_cnt_reader dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;
  int m_last = 0;
  int m_acc  = 0;
  int m_delta = 0;
  bit m_err  = 1'b0;
  bit m_sat  = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int dut_acc();
    logic signed [15:0] t;
    t = bus.acc;
    return int'(t);
  endfunction

  function automatic int wrap16(input int v);
    logic signed [15:0] t;
    t = v[15:0];
    return int'(t);
  endfunction

  task automatic check_state(input string tag);
    chk({tag, "_acc"}, dut_acc(), m_acc);
    chk({tag, "_delta"}, int'(bus.delta), m_delta);
    chk({tag, "_err"}, int'(bus.step_err), int'(m_err));
    chk({tag, "_sat"}, int'(bus.sat), int'(m_sat));
  endtask

  // One stable counter change; model derives the expected step from ring distance.
  task automatic apply(input int val, input bit dir, input bit clr_upd, input string tag);
    int n, step, s;
    bit seen;
    @(negedge clk);
    bus.cnt_async = 4'(val);
    bus.up_down   = dir;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      bus.clr = (clr_upd && n == 5);
      if (bus.acc_valid) seen = 1'b1;
    end
    bus.clr = 1'b0;
    step = dir ? (val - m_last + 16) % 16 : -((m_last - val + 16) % 16);
    m_last  = val;
    m_delta = step & 15;
    if (step > 4 || step < -4) m_err = 1'b1;
    s = m_acc + step;
`ifdef RCR_SATURATE_EN
    if (s > 32767) begin s = 32767; m_sat = 1'b1; end
    else if (s < -32768) begin s = -32768; m_sat = 1'b1; end
    m_acc = s;
`else
    m_acc = wrap16(s);
`endif
    if (clr_upd) begin
      m_acc = 0;
      m_err = 1'b0;
      m_sat = 1'b0;
    end
    chk({tag, "_latency"}, n, 6);
    check_state(tag);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_pulse_end"}, int'(bus.acc_valid), 0);
  endtask

  task automatic do_clr();
    @(negedge clk);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    m_acc = 0;
    m_err = 1'b0;
    m_sat = 1'b0;
  endtask

  task automatic quiet_window(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.acc_valid) seen++;
    end
    chk(tag, seen, 0);
  endtask

  initial begin
    int mag, val, step;
    bit dir;
    bus.cnt_async = '0;
    bus.up_down   = 1'b1;
    bus.clr       = 1'b0;
    repeat (3) @(negedge clk);
    check_state("reset");
    chk("reset_valid", int'(bus.acc_valid), 0);
    rst = 1'b0;

    apply(1, 1'b1, 1'b0, "first_up");

    @(negedge clk);
    bus.cnt_async = 4'd7;
    @(negedge clk);
    bus.cnt_async = 4'(m_last);
    quiet_window("glitch_no_valid", 15);
    check_state("glitch");
    apply(3, 1'b1, 1'b0, "after_glitch");

    apply(7, 1'b1, 1'b0, "up4_a");
    apply(11, 1'b1, 1'b0, "up4_b");
    apply(15, 1'b1, 1'b0, "up4_c");
    apply(0, 1'b1, 1'b0, "wrap_up");
    chk("wrap_up_delta_const", int'(bus.delta), 1);
    apply(15, 1'b0, 1'b0, "wrap_down");
    chk("wrap_down_delta_const", int'(bus.delta), 15);
    chk("wrap_net_acc", dut_acc(), 15);

    apply(0, 1'b1, 1'b0, "pre_big");
    apply(6, 1'b1, 1'b0, "big_step");
    chk("big_step_err_const", int'(bus.step_err), 1);
    apply(7, 1'b1, 1'b0, "err_sticky");
    do_clr();
    check_state("clr");
    chk("clr_acc_const", dut_acc(), 0);

    apply(11, 1'b1, 1'b0, "to2_a");
    apply(15, 1'b1, 1'b0, "to2_b");
    apply(2, 1'b1, 1'b0, "to2_c");
    apply(3, 1'b1, 1'b1, "clr_in_update");
    apply(4, 1'b1, 1'b0, "after_clr_update");
    chk("after_clr_update_const", dut_acc(), 1);

    for (int i = 0; i < 40; i++) begin
      dir = 1'($urandom_range(0, 1));
      mag = int'($urandom_range(1, 5));
      val = dir ? (m_last + mag) % 16 : (m_last - mag + 16) % 16;
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        bus.cnt_async = 4'((val + 8) % 16);
      end
      apply(val, dir, 1'b0, "random");
    end

    do_clr();
    while (m_acc < 32767) begin
      step = (32767 - m_acc > 15) ? 15 : 32767 - m_acc;
      apply((m_last + step) % 16, 1'b1, 1'b0, "fill");
    end
    chk("fill_top", dut_acc(), 32767);
    apply((m_last + 1) % 16, 1'b1, 1'b0, "overflow");
`ifdef RCR_SATURATE_EN
    chk("overflow_acc_const", dut_acc(), 32767);
    chk("overflow_sat_const", int'(bus.sat), 1);
`else
    chk("overflow_acc_const", dut_acc(), -32768);
    chk("overflow_sat_const", int'(bus.sat), 0);
`endif

    @(negedge clk);
    bus.cnt_async = 4'((m_last + 2) % 16);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus.cnt_async = '0;
    #1;
    m_acc = 0; m_delta = 0; m_err = 1'b0; m_sat = 1'b0; m_last = 0;
    check_state("rst_mid");
    chk("rst_mid_valid", int'(bus.acc_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    quiet_window("rst_no_valid", 15);
    apply(2, 1'b1, 1'b0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
